// File: rtl/maple_tx.sv
// maple_tx: Maple bus frame transmitter. Pops FIFO bytes and drives start/data/end patterns.
// Define MAPLE_TX_CHECKSUM_EN to append an XOR checksum byte before the end pattern.
module maple_tx #(
   parameter int unsigned DIV = 10
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       start_i,
   input  logic [7:0] count_i,
   input  logic [7:0] fifo_data_i,
   input  logic       fifo_avail_i,
   output logic       fifo_strobe_o,
   output logic       sdcka_o,
   output logic       sdckb_o,
   output logic       drive_en_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       underrun_o
);

   localparam int unsigned TickW = $clog2(DIV);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StBits,
`ifdef MAPLE_TX_CHECKSUM_EN
      StCsum,
`endif
      StEnd
   } state_e;

   state_e           state_q, state_d;
   logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
   logic [3:0]       idx_q, idx_d;
   logic [7:0]       byte_cnt_q, byte_cnt_d;
   logic [7:0]       data_q, data_d;
   logic             underrun_q, underrun_d;
   logic             drive_en_q, drive_en_d;
   logic             done_q, done_d;
   logic             sdcka_q, sdcka_d;
   logic             sdckb_q, sdckb_d;
`ifdef MAPLE_TX_CHECKSUM_EN
   logic [7:0]       csum_q, csum_d;
`endif

   logic tick_end;
   logic fetch_slot;
   logic fetch_go;

   // Line pair {A,B} held during tick idx of the given state.
   function automatic logic [1:0] line_enc(input state_e st, input logic [3:0] idx,
                                           input logic [7:0] data);
      logic [2:0] pos;
      logic       bit_v;
      logic [1:0] enc;
      pos   = 3'd7 - idx[3:1];
      bit_v = data[pos];
      unique case (st)
         StStart: begin
            if (idx == 4'd0) begin
               enc = 2'b01;
            end else if (idx == 4'd9) begin
               enc = 2'b11;
            end else begin
               enc = {1'b0, ~idx[0]};
            end
         end
`ifdef MAPLE_TX_CHECKSUM_EN
         StBits, StCsum: begin
`else
         StBits: begin
`endif
            // Bits 7,5,3,1 clock on A with data on B; bits 6,4,2,0 swap the roles.
            if (!idx[1]) begin
               enc = {~idx[0], bit_v};
            end else begin
               enc = {bit_v, ~idx[0]};
            end
         end
         StEnd:   enc = {(~idx[0]) | (idx == 4'd5), idx == 4'd5};
         default: enc = 2'b11;
      endcase
      return enc;
   endfunction

   assign tick_end   = (tick_cnt_q == TickW'(DIV - 1));
   assign fetch_slot = tick_end && (((state_q == StStart) && (idx_q == 4'd9)) ||
                                    ((state_q == StBits) && (idx_q == 4'd15)));
   assign fetch_go   = fetch_slot && (byte_cnt_q != 8'd0) && fifo_avail_i;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         tick_cnt_q <= '0;
         idx_q      <= '0;
         byte_cnt_q <= '0;
         data_q     <= '0;
         underrun_q <= 1'b0;
         drive_en_q <= 1'b0;
         done_q     <= 1'b0;
         sdcka_q    <= 1'b1;
         sdckb_q    <= 1'b1;
`ifdef MAPLE_TX_CHECKSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         idx_q      <= idx_d;
         byte_cnt_q <= byte_cnt_d;
         data_q     <= data_d;
         underrun_q <= underrun_d;
         drive_en_q <= drive_en_d;
         done_q     <= done_d;
         sdcka_q    <= sdcka_d;
         sdckb_q    <= sdckb_d;
`ifdef MAPLE_TX_CHECKSUM_EN
         csum_q     <= csum_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      idx_d      = idx_q;
      byte_cnt_d = byte_cnt_q;
      data_d     = data_q;
      underrun_d = underrun_q;
      drive_en_d = drive_en_q;
      done_d     = 1'b0;
`ifdef MAPLE_TX_CHECKSUM_EN
      csum_d     = csum_q;
`endif
      if (state_q != StIdle) begin
         tick_cnt_d = tick_end ? '0 : tick_cnt_q + 1'b1;
      end
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d    = StStart;
               tick_cnt_d = '0;
               idx_d      = '0;
               byte_cnt_d = count_i;
               underrun_d = 1'b0;
               drive_en_d = 1'b1;
`ifdef MAPLE_TX_CHECKSUM_EN
               csum_d     = '0;
`endif
            end
         end
         StStart, StBits: begin
            if (fetch_slot) begin
               idx_d = '0;
               if (fetch_go) begin
                  state_d    = StBits;
                  data_d     = fifo_data_i;
                  byte_cnt_d = byte_cnt_q - 8'd1;
`ifdef MAPLE_TX_CHECKSUM_EN
                  csum_d     = csum_q ^ fifo_data_i;
`endif
               end else begin
                  // Out of bytes: either the frame is complete or the FIFO ran dry.
                  underrun_d = underrun_q | (byte_cnt_q != 8'd0);
`ifdef MAPLE_TX_CHECKSUM_EN
                  state_d    = StCsum;
                  data_d     = csum_q;
`else
                  state_d    = StEnd;
`endif
               end
            end else if (tick_end) begin
               idx_d = idx_q + 4'd1;
            end
         end
`ifdef MAPLE_TX_CHECKSUM_EN
         StCsum: begin
            if (tick_end) begin
               if (idx_q == 4'd15) begin
                  state_d = StEnd;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
`endif
         StEnd: begin
            if (tick_end) begin
               if (idx_q == 4'd5) begin
                  state_d    = StIdle;
                  idx_d      = '0;
                  drive_en_d = 1'b0;
                  done_d     = 1'b1;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
      {sdcka_d, sdckb_d} = line_enc(state_d, idx_d, data_d);
   end

   always_comb begin
      fifo_strobe_o = fetch_go;
      busy_o        = (state_q != StIdle);
      sdcka_o       = sdcka_q;
      sdckb_o       = sdckb_q;
      drive_en_o    = drive_en_q;
      done_o        = done_q;
      underrun_o    = underrun_q;
   end

endmodule
